// File: rtl/compressor_tree_pipe_if.sv
// Valid/ready bundle for compressor_tree_pipe: packed operands in, carry-save (or summed) result out.
interface compressor_tree_pipe_if #(
    parameter int WIDTH   = 16,
    parameter int NUM_OPS = 8
);
    localparam int OW = WIDTH + $clog2(NUM_OPS);

    logic [NUM_OPS*WIDTH-1:0] in_ops;
    logic                     in_valid;
    logic                     in_ready;
    logic [OW-1:0]            out_sum;
    logic [OW-1:0]            out_carry;
    logic                     out_valid;
    logic                     out_ready;

    modport master (
        output in_ops, in_valid, out_ready,
        input  in_ready, out_sum, out_carry, out_valid
    );

    modport slave (
        input  in_ops, in_valid, out_ready,
        output in_ready, out_sum, out_carry, out_valid
    );
endinterface

// File: rtl/compressor_tree_pipe.sv
// Pipelined 4:2 carry-save reduction tree, one register bank per layer, full valid/ready backpressure.
// Define COMPRESSOR_TREE_FINAL_ADD_EN to append a registered carry-propagate add (out_carry tied to 0).
module compressor_tree_pipe #(
    parameter int WIDTH   = 16,
    parameter int NUM_OPS = 8
) (
    input logic                   clk,
    input logic                   rst,
    compressor_tree_pipe_if.slave bus
);
    localparam int OW = WIDTH + $clog2(NUM_OPS);
    localparam int L  = $clog2(NUM_OPS) - 1;

    // Row of 4:2 cells; returns {carry shifted to its weight, sum}. Carries out of bit OW-1 are dropped.
    function automatic logic [1:0][OW-1:0] compress42(input logic [OW-1:0] a, b, c, d);
        logic [OW-1:0] s;
        logic [OW-1:0] cs;
        logic          t;
        logic          ci;
        logic          co;
        logic          cm;
        ci = 1'b0;
        cm = 1'b0;
        for (int i = 0; i < OW; i++) begin
            cs[i] = cm;
            t     = a[i] ^ b[i] ^ c[i];
            co    = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
            s[i]  = t ^ d[i] ^ ci;
            cm    = (t & d[i]) | (t & ci) | (d[i] & ci);
            ci    = co;
        end
        return {cs, s};
    endfunction

    logic [L-1:0] v;
    logic [L-1:0] rdy;
    logic         ds_ready;

    for (genvar j = 0; j < L; j++) begin : g_layer
        localparam int M_IN  = NUM_OPS >> j;
        localparam int M_OUT = M_IN / 2;

        logic [M_IN-1:0][OW-1:0]  d_in;
        logic [M_OUT-1:0][OW-1:0] d_next;
        logic [M_OUT-1:0][OW-1:0] q;
        logic                     up_valid;
        logic                     v_q;

        if (j == 0) begin : g_src
            for (genvar k = 0; k < NUM_OPS; k++) begin : g_ext
                assign d_in[k] = OW'(bus.in_ops[k*WIDTH +: WIDTH]);
            end
            assign up_valid = bus.in_valid;
        end else begin : g_src
            assign d_in     = g_layer[j-1].q;
            assign up_valid = v[j-1];
        end

        // A stage may load whenever any stage from here to the output is empty or the sink takes data.
        assign rdy[j] = ds_ready | ~(&v[L-1:j]);

        always_comb begin
            // NOTE: default every always_comb output first so no path can infer a latch.
            d_next = '0;
            for (int g = 0; g < M_IN / 4; g++) begin
                {d_next[2*g+1], d_next[2*g]} =
                    compress42(d_in[4*g], d_in[4*g+1], d_in[4*g+2], d_in[4*g+3]);
            end
        end

        // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_q <= 1'b0;
                // NOTE: data registers are reset too, so outputs read zero throughout reset.
                q   <= '0;
            end else if (rdy[j]) begin
                v_q <= up_valid;
                q   <= d_next;
            end
        end

        assign v[j] = v_q;
    end

`ifdef COMPRESSOR_TREE_FINAL_ADD_EN
    logic          fin_v;
    logic [OW-1:0] fin_q;

    assign ds_ready = bus.out_ready | ~fin_v;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fin_v <= 1'b0;
            fin_q <= '0;
        end else if (ds_ready) begin
            fin_v <= v[L-1];
            fin_q <= g_layer[L-1].q[0] + g_layer[L-1].q[1];
        end
    end

    assign bus.out_valid = fin_v;
    assign bus.out_sum   = fin_q;
    assign bus.out_carry = '0;
`else
    assign ds_ready      = bus.out_ready;
    assign bus.out_valid = v[L-1];
    assign bus.out_sum   = g_layer[L-1].q[0];
    assign bus.out_carry = g_layer[L-1].q[1];
`endif

    assign bus.in_ready = rdy[0];
endmodule

// File: tb/tb_compressor_tree_pipe.sv
// Self-checking bench for compressor_tree_pipe: directed vectors, reset, backpressure, throughput,
// and NUM_OPS=4 / NUM_OPS=32 random sweeps against a plain-arithmetic reference.
module tb_compressor_tree_pipe;
    localparam int WIDTH   = 16;
    localparam int NUM_OPS = 8;
    localparam int OW      = WIDTH + $clog2(NUM_OPS);
    localparam int L       = $clog2(NUM_OPS) - 1;
`ifdef COMPRESSOR_TREE_FINAL_ADD_EN
    localparam int LAT     = L + 1;
`else
    localparam int LAT     = L;
`endif
    localparam int OW4     = WIDTH + 2;
    localparam int OW32    = WIDTH + 5;
    localparam int N_SWEEP = 1000;

    logic   clk   = 1'b0;
    logic   rst   = 1'b1;
    logic   rst_s = 1'b1;
    int     n_vec  = 0;
    int     n_miss = 0;
    longint exp_q[$];

    always #5 clk = ~clk;

    compressor_tree_pipe_if #(.WIDTH(WIDTH), .NUM_OPS(NUM_OPS)) m ();
    compressor_tree_pipe_if #(.WIDTH(WIDTH), .NUM_OPS(4))       s4 ();
    compressor_tree_pipe_if #(.WIDTH(WIDTH), .NUM_OPS(32))      s32 ();

    compressor_tree_pipe #(.WIDTH(WIDTH), .NUM_OPS(NUM_OPS)) dut   (.clk(clk), .rst(rst),   .bus(m));
    compressor_tree_pipe #(.WIDTH(WIDTH), .NUM_OPS(4))       dut4  (.clk(clk), .rst(rst_s), .bus(s4));
    compressor_tree_pipe #(.WIDTH(WIDTH), .NUM_OPS(32))      dut32 (.clk(clk), .rst(rst_s), .bus(s32));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        n_vec++;
        if (act !== want) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, want, $time);
        end
    endtask

    // Reference: the plain integer total of the first n operands.
    function automatic longint model_total(input logic [511:0] ops, input int n);
        longint t = 0;
        for (int k = 0; k < n; k++) t += longint'(ops[k*WIDTH +: WIDTH]);
        return t;
    endfunction

    function automatic longint pair_total(input longint s, input longint c, input int ow);
        return (s + c) & ((longint'(1) << ow) - 1);
    endfunction

    function automatic logic [511:0] rand_ops(input int n);
        logic [511:0] r = '0;
        logic         ones = ($urandom_range(0, 7) == 0);
        for (int k = 0; k < n; k++) r[k*WIDTH +: WIDTH] = ones ? 16'hFFFF : 16'($urandom);
        return r;
    endfunction

    // Compare process for the main instance: ordered results, stall stability, in_ready occupancy rule.
    initial begin
        logic          stall_prev = 1'b0;
        logic [OW-1:0] prev_sum   = '0;
        logic [OW-1:0] prev_carry = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_prev = 1'b0;
            end else begin
                if (m.out_valid) begin
                    if (exp_q.size() == 0) check("spurious_out", 64'(m.out_valid), 64'd0);
                    else check("result", 64'(pair_total(longint'(m.out_sum), longint'(m.out_carry), OW)),
                               64'(exp_q[0]));
`ifdef COMPRESSOR_TREE_FINAL_ADD_EN
                    check("carry_zero", 64'(m.out_carry), 64'd0);
`endif
                end
                if (stall_prev) begin
                    check("stall_valid", 64'(m.out_valid), 64'd1);
                    check("stall_hold", 64'({m.out_sum, m.out_carry}), 64'({prev_sum, prev_carry}));
                end
                check("in_ready", 64'(m.in_ready), 64'(m.out_ready || (exp_q.size() < LAT)));
                if (m.out_valid && m.out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
                if (m.in_valid && m.in_ready) exp_q.push_back(model_total(512'(m.in_ops), NUM_OPS));
                stall_prev = m.out_valid && !m.out_ready;
                prev_sum   = m.out_sum;
                prev_carry = m.out_carry;
            end
        end
    end

    task automatic send_one(input string name, input logic [127:0] ops, input longint want);
        int lat = 0;
        m.in_ops    = ops;
        m.in_valid  = 1'b1;
        m.out_ready = 1'b1;
        for (int i = 1; i <= LAT + 4 && lat == 0; i++) begin
            @(posedge clk); #1;
            m.in_valid = 1'b0;
            if (m.out_valid) begin
                lat = i;
                check({name, "_value"},
                      64'(pair_total(longint'(m.out_sum), longint'(m.out_carry), OW)), 64'(want));
            end
        end
        check({name, "_latency"}, 64'(lat), 64'(LAT));
    endtask

    task automatic drain_main(input string name);
        m.out_ready = 1'b1;
        for (int i = 0; i < 50 && exp_q.size() > 0; i++) @(posedge clk);
        #1;
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic run_main();
        logic [127:0] ops;
        logic [511:0] r;
        logic         acc;
        int           sent = 0;
        int           cyc  = 0;

        m.in_valid  = 1'b0;
        m.in_ops    = '0;
        m.out_ready = 1'b1;
        check("rst_valid",    64'(m.out_valid), 64'd0);
        check("rst_sum",      64'(m.out_sum),   64'd0);
        check("rst_carry",    64'(m.out_carry), 64'd0);
        check("rst_in_ready", 64'(m.in_ready),  64'd1);
        rst = 1'b0;
        @(posedge clk); #1;

        ops = '1;
        send_one("all_ones", ops, 64'h7FFF8);
        for (int k = 0; k < NUM_OPS; k++) ops[k*WIDTH +: WIDTH] = 16'(k + 1);
        send_one("ramp", ops, 36);
        ops = '0;
        send_one("zeros", ops, 0);
        drain_main("directed_drain");

        // Two results in flight, then an asynchronous reset between clock edges.
        for (int k = 0; k < NUM_OPS; k++) ops[k*WIDTH +: WIDTH] = 16'h1111;
        m.in_ops   = ops;
        m.in_valid = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < NUM_OPS; k++) ops[k*WIDTH +: WIDTH] = 16'h2222;
        m.in_ops = ops;
        @(posedge clk); #1;
        m.in_valid = 1'b0;
        #1;
        check("pre_rst_valid", 64'(m.out_valid), 64'(LAT == 2));
        #1 rst = 1'b1;
        #1;
        check("async_rst_valid", 64'(m.out_valid), 64'd0);
        check("async_rst_sum",   64'(m.out_sum),   64'd0);
        check("async_rst_carry", 64'(m.out_carry), 64'd0);
        exp_q.delete();
        @(posedge clk); #3 rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("flush_quiet", 64'(m.out_valid), 64'd0);
        end
        @(posedge clk); #1;

        // Back-to-back stream under out_ready = 1,0,0,...
        r = rand_ops(NUM_OPS);
        m.in_ops    = r[127:0];
        m.in_valid  = 1'b1;
        m.out_ready = 1'b1;
        while (sent < 10 && cyc < 300) begin
            @(negedge clk);
            acc = m.in_valid && m.in_ready;
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                sent++;
                r = rand_ops(NUM_OPS);
                m.in_ops = r[127:0];
                if (sent == 10) m.in_valid = 1'b0;
            end
            m.out_ready = (cyc % 3 == 0);
        end
        check("bp_sent", 64'(sent), 64'd10);
        drain_main("bp_drain");

        // Full pipeline streaming: one accept and one emit per cycle.
        m.out_ready = 1'b1;
        m.in_valid  = 1'b1;
        r = rand_ops(NUM_OPS);
        m.in_ops = r[127:0];
        for (int i = 0; i < LAT + 20; i++) begin
            @(negedge clk);
            if (i >= LAT) begin
                check("tp_out_valid", 64'(m.out_valid), 64'd1);
                check("tp_in_ready",  64'(m.in_ready),  64'd1);
            end
            @(posedge clk); #1;
            r = rand_ops(NUM_OPS);
            m.in_ops = r[127:0];
        end
        m.in_valid = 1'b0;
        drain_main("tp_drain");
    endtask

    task automatic run_sweep4();
        longint       q[$];
        int           acc = 0;
        int           got = 0;
        logic         take;
        logic [511:0] r;
        s4.in_valid  = 1'b0;
        s4.in_ops    = '0;
        s4.out_ready = 1'b0;
        for (int cyc = 0; cyc < 8000 && got < N_SWEEP; cyc++) begin
            @(negedge clk);
            if (s4.out_valid && s4.out_ready) begin
                got++;
                if (q.size() == 0) check("s4_spurious", 64'(s4.out_valid), 64'd0);
                else check("s4_invariant",
                           64'(pair_total(longint'(s4.out_sum), longint'(s4.out_carry), OW4)),
                           64'(q.pop_front()));
            end
            take = s4.in_valid && s4.in_ready;
            if (take) begin
                q.push_back(model_total(512'(s4.in_ops), 4));
                acc++;
            end
            @(posedge clk); #1;
            if (take || !s4.in_valid) begin
                r = rand_ops(4);
                s4.in_ops   = r[63:0];
                s4.in_valid = (acc < N_SWEEP) && ($urandom_range(0, 3) != 0);
            end
            s4.out_ready = ($urandom_range(0, 3) != 0);
        end
        check("s4_count", 64'(got), 64'(N_SWEEP));
    endtask

    task automatic run_sweep32();
        longint       q[$];
        int           acc = 0;
        int           got = 0;
        logic         take;
        logic [511:0] r;
        s32.in_valid  = 1'b0;
        s32.in_ops    = '0;
        s32.out_ready = 1'b0;
        for (int cyc = 0; cyc < 8000 && got < N_SWEEP; cyc++) begin
            @(negedge clk);
            if (s32.out_valid && s32.out_ready) begin
                got++;
                if (q.size() == 0) check("s32_spurious", 64'(s32.out_valid), 64'd0);
                else check("s32_invariant",
                           64'(pair_total(longint'(s32.out_sum), longint'(s32.out_carry), OW32)),
                           64'(q.pop_front()));
            end
            take = s32.in_valid && s32.in_ready;
            if (take) begin
                q.push_back(model_total(s32.in_ops, 32));
                acc++;
            end
            @(posedge clk); #1;
            if (take || !s32.in_valid) begin
                r = rand_ops(32);
                s32.in_ops   = r;
                s32.in_valid = (acc < N_SWEEP) && ($urandom_range(0, 3) != 0);
            end
            s32.out_ready = ($urandom_range(0, 3) != 0);
        end
        check("s32_count", 64'(got), 64'(N_SWEEP));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "simulation timeout");
    end

    initial begin
        #23;
        rst_s = 1'b0;
        fork
            run_main();
            run_sweep4();
            run_sweep32();
        join
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/compressor_tree_pipe.md
Name: compressor_tree_pipe

Overview:
- Parametrised, pipelined carry-save reduction tree built from rows of 4:2 compressor cells.
- Reduces NUM_OPS unsigned operands of WIDTH bits to one sum/carry vector pair, with one register stage per compressor layer.
- Sits between the Booth partial-product generator and the final carry-propagate adder in the multiplier datapath.
- Valid/ready handshake on both sides with full backpressure support.

Parameters:
- WIDTH, 16, bit width of each input operand (≥2).
- NUM_OPS, 8, number of operands; power of two, 4..32.
- OW, WIDTH+$clog2(NUM_OPS), output vector width; derived, do not override.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_ops  input  NUM_OPS*WIDTH  packed operands; operand k occupies bits [k*WIDTH +: WIDTH].
- in_valid  input  1  in_ops is valid this cycle.
- in_ready  output  1  tree accepts in_ops this cycle.
- out_sum  output  OW  sum vector.
- out_carry  output  OW  carry vector, already weight-aligned (shifted left 1) and added directly to out_sum.
- out_valid  output  1  out_sum/out_carry valid.
- out_ready  input  1  downstream accepts the output.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high. While rst=1, every stage valid bit =0 and every data register =0, so out_valid=0, out_sum=0, out_carry=0. Any data in flight when reset asserts is discarded with no output.
- Layers: L = $clog2(NUM_OPS)-1.
  - Layer j takes M_j vectors and emits M_j/2 vectors (groups of 4 → sum, carry).
  - Each cell chains its intermediate carry to the next higher bit position of the same group; the LSB intermediate carry-in is 0.
  - Example: NUM_OPS=8 → 8→4→2, L=2.
- Operand extension: operands are zero-extended to OW before layer 0. Carries beyond bit OW-1 are dropped. No information is lost, because the true total is < 2^OW.
- Pipeline: one register bank after each layer. Latency is L cycles from input acceptance to out_valid when out_ready=1. Throughput is one result per cycle.
- Handshake, per stage k (0..L-1):
  - Stage k is ready when v[k]=0, or when stage k+1 is ready.
  - The last stage uses out_ready as its downstream ready.
  - in_ready = ready of stage 0, a combinational chain. It must not depend on in_valid.
  - Transfer happens on valid & ready. Stage k loads when its ready=1. v[k] takes the upstream valid, so bubbles collapse.
- Stall: when out_valid=1 and out_ready=0, out_sum, out_carry and out_valid hold stable. Upstream stages fill, then in_ready drops once all L stages are valid.
- Simultaneous accept and emit: a full pipeline with out_ready=1 and in_valid=1 moves every stage forward and accepts a new input in the same cycle.
- Ordering: results leave strictly in input order. No reordering, duplication or loss.
- Arithmetic invariant for every emitted result: (out_sum + out_carry) mod 2^OW == Σ in_ops[k] exactly.
- Data registers of invalid stages may hold stale values. Only out_valid qualifies the outputs.

Optional Feature:
- Macro: COMPRESSOR_TREE_FINAL_ADD_EN.
- Defined:
  - Adds one further register stage holding a carry-propagate add of the last sum/carry pair. Latency becomes L+1.
  - out_sum = exact total (OW bits). out_carry is driven constant 0.
  - This stage follows the same valid/ready rules.
- Undefined: outputs are the carry-save pair, latency L, no adder is instantiated.

Test Plan:
- Reset mid-stream: rst is pulsed asynchronously, between clock edges, while 2 results are in flight. out_valid must fall at once with no clock edge needed, out_sum=out_carry=0, and neither in-flight result ever appears.
- Directed values, WIDTH=16, NUM_OPS=8, all operands 16'hFFFF, out_ready=1: out_valid rises 2 cycles after acceptance. The pair sums to 19'h7FFF8 (one stage later with the macro defined).
- Mixed operands 1,2,3,4,5,6,7,8: pair sums to 36. Operands all 0: pair sums to 0.
- Backpressure:
  - Stream 10 back-to-back random inputs while toggling out_ready 1,0,0,1,...
  - Outputs must hold stable while stalled and arrive in order, each matching the reference sum.
  - in_ready must fall only when all stages are valid and out_ready=0.
- Full pipeline with simultaneous in_valid=1 and out_ready=1: one accept and one emit per cycle for 20 cycles, with no bubbles.
- Parameter sweep: NUM_OPS=4 (L=1) and NUM_OPS=32 (L=4, OW=WIDTH+5) with 1000 random vectors each. The arithmetic invariant must hold for every output.
